// File: rtl/mod_enc_mixcolumns.sv
// AES-256 encryption MixColumns stage with a registered output.
// Latency: 4/COLS_PER_CYCLE cycles from accept to out_valid, or 1 cycle when bypass=1.
// Backpressure: the result is held while out_ready=0, and in_ready drops until the result is taken.
module mod_enc_mixcolumns #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bypass,
  input  logic [15:0][7:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] out
);

  typedef logic [3:0][7:0] col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    BYP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // This is the column index that holds the last group of a block.
  // When COLS_PER_CYCLE is 4, it wraps to 0, so the block finishes in one BUSY cycle.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       col;
  logic [15:0][7:0] st;
  logic [15:0][7:0] out_nxt;
  logic             accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // This computes one MixColumns column.
  // Index r of a and b is the row.
  function automatic col_t mix_col(input col_t a);
    col_t b;
    b[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
    b[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
    b[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
    b[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    return b;
  endfunction

  // The stage accepts a new state when it is idle.
  // It also accepts one on the same edge that the finished result leaves.
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // This merges the columns computed this cycle into the current output.
  // The byte index {row, col} selects row r of column c.
  always_comb begin : mix_merge
    logic [1:0] c;
    col_t       a;
    col_t       b;
    c       = '0;
    a       = '0;
    b       = '0;
    out_nxt = out;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      c = col + 2'(k);
      for (int r = 0; r < 4; r++) begin
        a[r] = st[{2'(r), c}];
      end
      b = mix_col(a);
      for (int r = 0; r < 4; r++) begin
        out_nxt[{2'(r), c}] = b[r];
      end
    end
  end

  // This is the next-state logic for the block sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = bypass ? BYP : BUSY;
      BUSY: if (col == LAST_COL) state_nxt = DONE;
      BYP:  state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_nxt = bypass ? BYP : BUSY;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // This is the state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // This is the datapath.
  // It latches the input on accept, fills the output column by column, and holds it in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      st        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        st  <= in;
        col <= '0;
      end
      case (state)
        BUSY: begin
          out <= out_nxt;
          col <= col + COL_STEP;
          if (col == LAST_COL) out_valid <= 1'b1;
        end
        BYP: begin
          out       <= st;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_enc_mixcolumns.sv
// Directed bench for mod_enc_mixcolumns with instances for 1, 2 and 4 columns per cycle.
// Inputs are driven 1 time unit after posedge, and outputs are sampled at the same point.
// Expected states come from hand-computed MixColumns column vectors.
module tb_mod_enc_mixcolumns;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             bypass;
  logic [15:0][7:0] din;
  logic [2:0]       in_valid_v;
  logic [2:0]       out_ready_v;
  logic             in_ready_0, in_ready_1, in_ready_2;
  logic             out_valid_0, out_valid_1, out_valid_2;
  logic [15:0][7:0] out_0, out_1, out_2;

  int checks = 0;
  int errors = 0;

  mod_enc_mixcolumns #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_0),
    .bypass(bypass), .in(din), .out_valid(out_valid_0), .out_ready(out_ready_v[0]), .out(out_0));
  mod_enc_mixcolumns #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_1),
    .bypass(bypass), .in(din), .out_valid(out_valid_1), .out_ready(out_ready_v[1]), .out(out_1));
  mod_enc_mixcolumns #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_2),
    .bypass(bypass), .in(din), .out_valid(out_valid_2), .out_ready(out_ready_v[2]), .out(out_2));

  function automatic logic in_ready_of(input int idx);
    return (idx == 0) ? in_ready_0 : (idx == 1) ? in_ready_1 : in_ready_2;
  endfunction
  function automatic logic out_valid_of(input int idx);
    return (idx == 0) ? out_valid_0 : (idx == 1) ? out_valid_1 : out_valid_2;
  endfunction
  function automatic logic [127:0] out_of(input int idx);
    return (idx == 0) ? out_0 : (idx == 1) ? out_1 : out_2;
  endfunction

  // The argument holds four columns {c0,c1,c2,c3}, with c0 in the most significant word.
  // Within each column the word is {a0,a1,a2,a3}.
  // This function builds the state with byte 4*r+c = row r of column c.
  function automatic logic [15:0][7:0] mk(input logic [127:0] cols);
    logic [15:0][7:0] s;
    s = '0;
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++)
        s[4*r+k] = cols[127-32*k-8*r -: 8];
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  localparam logic [127:0] T2_IN  = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] T2_EXP = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] T3_IN  = {32'hd4d4d4d5, 32'h2d26314c, 32'h00000000, 32'hffffffff};
  localparam logic [127:0] T3_EXP = {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h00000000, 32'hffffffff};

  typedef struct {
    logic [127:0] icols;
    logic         byp;
    logic [127:0] ecols;
  } vec_t;

  // This task sends one block to instance idx.
  // It checks accept-to-valid latency and the result, then releases the result.
  task automatic run_block(input int idx, input logic [127:0] icols, input logic byp,
                           input logic [127:0] ecols, input string tag);
    int lat_exp;
    int n;
    lat_exp = byp ? 1 : ((idx == 0) ? 4 : (idx == 1) ? 2 : 1);
    chk({tag, " in_ready"}, 128'(in_ready_of(idx)), 128'd1);
    din = mk(icols);
    bypass = byp;
    in_valid_v[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid_of(idx) && n < 20);
    chk({tag, " latency"}, 128'(n), 128'(lat_exp));
    chk({tag, " out"}, out_of(idx), mk(ecols));
    out_ready_v[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[idx] = 1'b0;
    chk({tag, " released"}, 128'(out_valid_of(idx)), 128'd0);
  endtask

  initial begin
    vec_t vecs[4];
    int   n;
    vecs[0] = '{T2_IN, 1'b0, T2_EXP};
    vecs[1] = '{T3_IN, 1'b0, T3_EXP};
    vecs[2] = '{T2_IN, 1'b1, T2_IN};
    vecs[3] = '{T3_IN, 1'b1, T3_IN};

    rst = 1'b1; bypass = 1'b0; din = '0; in_valid_v = '0; out_ready_v = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // This checks the state just after reset, on every instance.
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d out", i), out_of(i), 128'd0);
      chk($sformatf("reset%0d out_valid", i), 128'(out_valid_of(i)), 128'd0);
      chk($sformatf("reset%0d in_ready", i), 128'(in_ready_of(i)), 128'd1);
    end

    // This applies the vector table to each columns-per-cycle variant.
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 4; v++)
        run_block(i, vecs[v].icols, vecs[v].byp, vecs[v].ecols, $sformatf("vec%0d_inst%0d", v, i));

    // This holds the result under backpressure, then does a back-to-back release and accept.
    din = mk(T2_IN); bypass = 1'b0; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid_0 && n < 20);
    chk("hold latency", 128'(n), 128'd4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d out", c), out_0, mk(T2_EXP));
      chk($sformatf("hold%0d out_valid", c), 128'(out_valid_0), 128'd1);
      chk($sformatf("hold%0d in_ready", c), 128'(in_ready_0), 128'd0);
    end
    din = mk(T3_IN); in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    #1 chk("b2b in_ready", 128'(in_ready_0), 128'd1);
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b0;
    chk("b2b out_valid dropped", 128'(out_valid_0), 128'd0);
    chk("b2b busy in_ready", 128'(in_ready_0), 128'd0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid_0 && n < 20);
    chk("b2b latency", 128'(n), 128'd4);
    chk("b2b out", out_0, mk(T3_EXP));
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;

    // This asserts reset in the middle of a block, at BUSY with col=2.
    din = mk(T2_IN); bypass = 1'b0; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midblk out_valid", 128'(out_valid_0), 128'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst out", out_0, 128'd0);
    chk("midrst out_valid", 128'(out_valid_0), 128'd0);
    chk("midrst in_ready", 128'(in_ready_0), 128'd1);
    run_block(0, T3_IN, 1'b0, T3_EXP, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
